// File: rtl/sm_acc_pkg.sv
// sm_acc_pkg: shared state encoding and negative-zero canonicalisation for sm_accumulate_ctrl
package sm_acc_pkg;
    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
    localparam int SM_MAX_W = 64;
    function automatic logic [SM_MAX_W-1:0] sm_norm(input logic [SM_MAX_W-1:0] v, input int unsigned w);
        logic [SM_MAX_W-1:0] mask;
        mask = (SM_MAX_W'(1) << (w - 1)) - SM_MAX_W'(1);
        return ((v & mask) == '0) ? '0 : v;
    endfunction
endpackage

// File: rtl/sm_accumulate_ctrl_adder.sv
// SignMagnitudeAdder: combinational sign-magnitude adder (a = accumulator, b = term; b wins ties); ports a, b in, result out
module SignMagnitudeAdder #(
    parameter int WIDTH_A      = 32,
    parameter int WIDTH_B      = 32,
    parameter int WIDTH_RESULT = 32
) (
    input  logic [WIDTH_A-1:0]      a,
    input  logic [WIDTH_B-1:0]      b,
    output logic [WIDTH_RESULT-1:0] result
);
    localparam int M = WIDTH_RESULT - 1;
    logic [M-1:0] ma, mb;
    logic         sa, sb;
    assign ma = M'(a[WIDTH_A-2:0]);
    assign mb = M'(b[WIDTH_B-2:0]);
    assign sa = a[WIDTH_A-1];
    assign sb = b[WIDTH_B-1];
    always_comb begin
        result = (sa == sb) ? {sa, ma + mb} : (ma > mb) ? {sa, ma - mb} : {sb, mb - ma};
    end
endmodule

// File: rtl/sm_accumulate_ctrl.sv
// sm_accumulate_ctrl: accumulates a stream of sign-magnitude terms onto a bias through one shared adder
// Ports: clk, rst (async active-high); start/len/bias launch a run; in_valid/in_ready/in_data term stream;
// out_valid/out_ready/out_data/out_ovf result; busy = not IDLE.
// Option: define SM_ACC_SAT_EN to saturate on magnitude overflow; otherwise the magnitude wraps.
module sm_accumulate_ctrl
    import sm_acc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic [WIDTH-1:0] bias,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic             busy
);
    localparam logic [WIDTH-2:0] MAG_MAX = '1;
    function automatic logic [WIDTH-1:0] norm(input logic [WIDTH-1:0] v);
        return WIDTH'(sm_norm(SM_MAX_W'(v), WIDTH));
    endfunction
    state_t           state;
    logic [WIDTH-1:0] acc, term, sum, acc_nxt;
    logic [CNT_W-1:0] cnt;
    logic             ovf, carry;
    assign term = norm(in_data);
    SignMagnitudeAdder #(.WIDTH_A(WIDTH), .WIDTH_B(WIDTH), .WIDTH_RESULT(WIDTH)) u_add (
        .a(acc),
        .b(term),
        .result(sum)
    );
    // With equal signs a truncated magnitude sum below the addend means the carry-out was lost
    assign carry = (acc[WIDTH-1] == term[WIDTH-1]) && (sum[WIDTH-2:0] < acc[WIDTH-2:0]);
`ifdef SM_ACC_SAT_EN
    assign acc_nxt = norm(carry ? {acc[WIDTH-1], MAG_MAX} : sum);
`else
    assign acc_nxt = norm(sum);
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    acc   <= norm(bias);
                    cnt   <= len;
                    ovf   <= 1'b0;
                    state <= (len == '0) ? DONE : ACC;
                end
                ACC: if (in_valid) begin
                    acc <= acc_nxt;
                    ovf <= ovf | carry;
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) state <= DONE;
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
    assign in_ready  = (state == ACC);
    assign out_valid = (state == DONE);
    assign out_data  = out_valid ? acc : '0;
    assign out_ovf   = out_valid & ovf;
    assign busy      = (state != IDLE);
endmodule

// File: tb/tb_sm_accumulate_ctrl.sv
// tb_sm_accumulate_ctrl: directed and random scoreboard bench for sm_accumulate_ctrl at WIDTH=8
module tb_sm_accumulate_ctrl;
    localparam int WIDTH = 8;
    localparam int CNT_W = 10;
    typedef struct {logic [7:0] d; logic o;} exp_t;
    logic             clk = 0, rst = 1, start = 0, in_valid = 0, out_ready = 0;
    logic [CNT_W-1:0] len = '0;
    logic [7:0]       bias = '0, in_data = '0;
    logic             in_ready, out_valid, out_ovf, busy;
    logic [7:0]       out_data;
    int               passed = 0, total = 0;
    logic [7:0]       m_acc;
    logic             m_ovf;
    exp_t             sb[$];
    sm_accumulate_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .bias(bias),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ovf(out_ovf), .busy(busy)
    );
    always #5 clk = ~clk;
    function automatic logic [8:0] madd(input logic [7:0] a, input logic [7:0] t);
        int va, vt, s, mag;
        logic o;
        va = a[7] ? -int'(a[6:0]) : int'(a[6:0]);
        vt = t[7] ? -int'(t[6:0]) : int'(t[6:0]);
        s = va + vt;
        mag = (s < 0) ? -s : s;
        o = mag > 127;
`ifdef SM_ACC_SAT_EN
        if (o) mag = 127;
`else
        mag = mag % 128;
`endif
        return {o, (mag == 0) ? 8'h00 : {s < 0, 7'(mag)}};
    endfunction
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask
    task automatic push_exp;
        exp_t e;
        e.d = m_acc;
        e.o = m_ovf;
        sb.push_back(e);
    endtask
    task automatic begin_acc(input logic [7:0] b, input int n);
        chk("idle_before_start", {31'd0, busy}, 0);
        start = 1;
        len = CNT_W'(n);
        bias = b;
        step;
        start = 0;
        m_acc = (b[6:0] == 0) ? 8'h00 : b;
        m_ovf = 0;
        chk("in_ready_after_start", {31'd0, in_ready}, {31'd0, n != 0});
        if (n == 0) push_exp;
    endtask
    task automatic send(input logic [7:0] t, input bit last);
        logic [8:0] r;
        chk("in_ready", {31'd0, in_ready}, 1);
        in_valid = 1;
        in_data = t;
        step;
        in_valid = 0;
        in_data = $urandom_range(255, 0);
        r = madd(m_acc, t);
        m_acc = r[7:0];
        m_ovf = m_ovf | r[8];
        if (last) push_exp;
    endtask
    task automatic finish_acc(input int hold, input bit poke);
        exp_t e;
        for (int i = 0; i < 40 && !out_valid; i++) step;
        chk("out_valid_wait", {31'd0, out_valid}, 1);
        e = sb.pop_front();
        for (int i = 0; i < hold; i++) begin
            if (poke && i == 1) begin
                start = 1;
                len = 2;
                bias = 8'h11;
            end
            step;
            start = 0;
            chk("hold_valid", {31'd0, out_valid}, 1);
            chk("hold_busy", {31'd0, busy}, 1);
            chk("hold_data", {24'd0, out_data}, {24'd0, e.d});
        end
        chk("out_data", {24'd0, out_data}, {24'd0, e.d});
        chk("out_ovf", {31'd0, out_ovf}, {31'd0, e.o});
        out_ready = 1;
        step;
        out_ready = 0;
        chk("idle_after_handshake", {30'd0, busy, out_valid}, 0);
    endtask
    initial begin
        step;
        step;
        chk("reset_outputs", {20'd0, in_ready, out_valid, out_data, out_ovf, busy}, 0);
        rst = 0;
        step;
        begin_acc(8'h05, 3);
        send(8'h0A, 0);
        send(8'h83, 0);
        send(8'h01, 1);
        chk("valid_cycle4", {31'd0, out_valid}, 1);
        chk("sum_0d", {24'd0, out_data}, 32'h0D);
        finish_acc(0, 0);
        begin_acc(8'h14, 1);
        send(8'h94, 1);
        chk("cancel_plus_zero", {24'd0, out_data}, 0);
        finish_acc(0, 0);
        begin_acc(8'h80, 0);
        chk("len0_valid_cycle1", {31'd0, out_valid}, 1);
        chk("neg_zero_bias", {24'd0, out_data}, 0);
        finish_acc(0, 0);
        begin_acc(8'h64, 1);
        send(8'h32, 1);
`ifdef SM_ACC_SAT_EN
        chk("overflow_sat", {23'd0, out_ovf, out_data}, 32'h17F);
`else
        chk("overflow_wrap", {23'd0, out_ovf, out_data}, 32'h116);
`endif
        finish_acc(0, 0);
        begin_acc(8'h10, 4);
        send(8'h05, 0);
        send(8'h03, 0);
        for (int i = 0; i < 3; i++) begin
            chk("gap_no_valid", {31'd0, out_valid}, 0);
            step;
        end
        send(8'h81, 0);
        send(8'h02, 1);
        chk("gap_valid_cycle8", {31'd0, out_valid}, 1);
        chk("gap_sum", {24'd0, out_data}, 32'h19);
        finish_acc(0, 0);
        begin_acc(8'h70, 2);
        send(8'h20, 0);
        send(8'h85, 1);
        finish_acc(5, 1);
        begin_acc(8'h30, 4);
        send(8'h01, 0);
        send(8'h02, 0);
        #2 rst = 1;
        #1 chk("async_reset", {20'd0, in_ready, out_valid, out_data, out_ovf, busy}, 0);
        #2 rst = 0;
        step;
        begin_acc(8'h02, 1);
        send(8'h03, 1);
        chk("after_reset_sum", {24'd0, out_data}, 32'h05);
        finish_acc(0, 0);
        for (int k = 0; k < 6; k++) begin
            int n;
            n = $urandom_range(5, 1);
            begin_acc(8'($urandom_range(255, 0)), n);
            for (int j = 0; j < n; j++) begin
                if ($urandom_range(3, 0) == 0) step;
                send(8'($urandom_range(255, 0)), j == n - 1);
            end
            finish_acc($urandom_range(2, 0), 0);
        end
        chk("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
